// File: rtl/int_pkg.sv
// Shared definitions for the interrupt/halt sequencer of the 65C02 core.
//   - Vector low bytes for NMI, RESET and IRQ/BRK.
//   - Sequencer state encoding (RUN / WAIT / STOP).
package int_pkg;

  localparam logic [7:0] VEC_NMI = 8'hFA;
  localparam logic [7:0] VEC_RST = 8'hFC;
  localparam logic [7:0] VEC_IRQ = 8'hFE;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    STOP = 2'd2
  } int_state_t;

endpackage

// File: rtl/int_edge.sv
// Pin conditioning for the interrupt sequencer.
//   Holds the optional 2-flop synchronizers on irq_n/nmi_n, the nmi_prev
//   register and the NMI set pulse.
// Configuration macro: INT_SYNC_EN (defined = synchronize both pins, each
//   synchronizer flop resets to 1; undefined = pins used directly).
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   irq_n_i      raw IRQ pin (active low, level)
//   nmi_n_i      raw NMI pin (active low)
//   irq_n_o      conditioned IRQ level
//   nmi_set_o    one cycle of "set nmi_pend" (edge or level, per NMI_EDGE)
module int_edge #(
  parameter int NMI_EDGE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic irq_n_i,
  input  logic nmi_n_i,
  output logic irq_n_o,
  output logic nmi_set_o
);

  logic irq_n_s;
  logic nmi_n_s;
  logic nmi_prev_q;

`ifdef INT_SYNC_EN
  logic irq_s1_q, irq_s2_q;
  logic nmi_s1_q, nmi_s2_q;

  // Reset to the inactive level so leaving reset never fakes an NMI edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_s1_q <= 1'b1;
      irq_s2_q <= 1'b1;
      nmi_s1_q <= 1'b1;
      nmi_s2_q <= 1'b1;
    end else begin
      irq_s1_q <= irq_n_i;
      irq_s2_q <= irq_s1_q;
      nmi_s1_q <= nmi_n_i;
      nmi_s2_q <= nmi_s1_q;
    end
  end

  assign irq_n_s = irq_s2_q;
  assign nmi_n_s = nmi_s2_q;
`else
  assign irq_n_s = irq_n_i;
  assign nmi_n_s = nmi_n_i;
`endif

  always_ff @(posedge clk) begin
    if (reset) nmi_prev_q <= 1'b1;
    else       nmi_prev_q <= nmi_n_s;
  end

  assign irq_n_o   = irq_n_s;
  // Level mode keeps re-setting nmi_pend while the pin is low.
  assign nmi_set_o = (NMI_EDGE != 0) ? (nmi_prev_q & ~nmi_n_s) : ~nmi_n_s;

endmodule

// File: rtl/int_ctl.sv
// Interrupt and halt sequencer for the 65C02 core.
//   Decides at each instruction boundary whether the microcode diverts to
//   the interrupt sequence, supplies the vector low byte and B flag, and
//   halts the core during WAI/STP.
// Configuration macro: INT_SYNC_EN (see int_edge).
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   irq_n, nmi_n interrupt pins (active low)
//   sync         instruction boundary this cycle
//   I            interrupt-disable flag
//   brk          opcode at sync is BRK
//   wai, stp     one-cycle pulses for WAI / STP
//   vec_fetch    microcode reads the vector low byte this cycle
//   take_int     combinational: divert to interrupt sequence
//   vec_lo       registered vector low byte
//   B            registered B bit for the pushed status
//   rdy          registered; 0 halts the core
//   state_o      debug view of the sequencer state
// Handshake: the core only advances while rdy=1; take_int is meaningful only
// in a cycle with sync=1, and vec_lo/B are stable from the edge after that
// sync until the next sync in RUN.
module int_ctl
  import int_pkg::*;
#(
  parameter int NMI_EDGE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       irq_n,
  input  logic       nmi_n,
  input  logic       sync,
  input  logic       I,
  input  logic       brk,
  input  logic       wai,
  input  logic       stp,
  input  logic       vec_fetch,
  output logic       take_int,
  output logic [7:0] vec_lo,
  output logic       B,
  output logic       rdy,
  output int_state_t state_o
);

  logic       irq_n_s;
  logic       nmi_set;
  logic       irq_eff;
  logic       run_sync;

  logic       rst_pend_q, rst_pend_d;
  logic       nmi_pend_q, nmi_pend_d;
  int_state_t state_q, state_d;
  logic       rdy_q, rdy_d;
  logic [7:0] vec_lo_q, vec_lo_d;
  logic       b_q, b_d;

  int_edge #(.NMI_EDGE(NMI_EDGE)) u_edge (
    .clk       (clk),
    .reset     (reset),
    .irq_n_i   (irq_n),
    .nmi_n_i   (nmi_n),
    .irq_n_o   (irq_n_s),
    .nmi_set_o (nmi_set)
  );

  assign irq_eff  = ~irq_n_s & ~I;
  assign run_sync = sync & (state_q == RUN);
  assign take_int = run_sync & (rst_pend_q | nmi_pend_q | irq_eff);

  always_comb begin
    rst_pend_d = rst_pend_q;
    nmi_pend_d = nmi_pend_q;
    state_d    = state_q;
    rdy_d      = rdy_q;
    vec_lo_d   = vec_lo_q;
    b_d        = b_q;

    // Clears come first so that a same-cycle NMI set overrides them.
    if (vec_fetch && vec_lo_q == VEC_RST) rst_pend_d = 1'b0;
    if (vec_fetch && vec_lo_q == VEC_NMI) nmi_pend_d = 1'b0;
    if (nmi_set)                          nmi_pend_d = 1'b1;

    if (run_sync) begin
      if (rst_pend_q) begin
        vec_lo_d = VEC_RST;
        b_d      = 1'b0;
      end else if (nmi_pend_q) begin
        vec_lo_d = VEC_NMI;
        b_d      = 1'b0;
      end else if (irq_eff) begin
        vec_lo_d = VEC_IRQ;
        b_d      = 1'b0;
      end else if (brk) begin
        vec_lo_d = VEC_IRQ;
        b_d      = 1'b1;
      end
    end

    case (state_q)
      RUN: begin
        if (stp) begin
          state_d = STOP;
          rdy_d   = 1'b0;
        end else if (wai) begin
          state_d = WAIT;
          rdy_d   = 1'b0;
        end
      end
      // Any IRQ level wakes WAI even when masked; whether it is then taken
      // is decided at the next sync by irq_eff.
      WAIT: begin
        if (~irq_n_s | nmi_pend_q) begin
          state_d = RUN;
          rdy_d   = 1'b1;
        end
      end
      STOP: begin
        state_d = STOP;
        rdy_d   = 1'b0;
      end
      default: begin
        state_d = RUN;
        rdy_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rst_pend_q <= 1'b1;
      nmi_pend_q <= 1'b0;
      state_q    <= RUN;
      rdy_q      <= 1'b1;
      vec_lo_q   <= VEC_RST;
      b_q        <= 1'b0;
    end else begin
      rst_pend_q <= rst_pend_d;
      nmi_pend_q <= nmi_pend_d;
      state_q    <= state_d;
      rdy_q      <= rdy_d;
      vec_lo_q   <= vec_lo_d;
      b_q        <= b_d;
    end
  end

  assign vec_lo  = vec_lo_q;
  assign B       = b_q;
  assign rdy     = rdy_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_int_ctl.sv
module tb_int_ctl;
  import int_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       irq_n, nmi_n, sync, I, brk, wai, stp, vec_fetch;
  logic       take_int;
  logic [7:0] vec_lo;
  logic       B, rdy;
  int_state_t state_o;

  always #5 clk = ~clk;

  int_ctl #(.NMI_EDGE(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_n     (irq_n),
    .nmi_n     (nmi_n),
    .sync      (sync),
    .I         (I),
    .brk       (brk),
    .wai       (wai),
    .stp       (stp),
    .vec_fetch (vec_fetch),
    .take_int  (take_int),
    .vec_lo    (vec_lo),
    .B         (B),
    .rdy       (rdy),
    .state_o   (state_o)
  );

  // ---------------- scoreboard ----------------
  // Entry = {take_int at sync, vec_lo after the edge, B after the edge}
  logic [9:0] exp_q[$];
  logic [9:0] exp_w;
  int n_cmp = 0;
  int n_err = 0;

  logic       obs_take;
  logic [7:0] obs_vec;
  logic       obs_b, obs_rdy;
  int_state_t obs_state;

  // ---------------- driver ----------------
  // Drives the per-cycle controls at the falling edge, samples the
  // combinational take_int mid-low-phase, then registered outputs #1 after
  // the rising edge.
  task automatic cycle(input logic s, input logic b, input logic vf,
                       input logic w, input logic st);
    @(negedge clk);
    sync = s; brk = b; vec_fetch = vf; wai = w; stp = st;
    #2 obs_take = take_int;
    @(posedge clk);
    #1;
    obs_vec   = vec_lo;
    obs_b     = B;
    obs_rdy   = rdy;
    obs_state = state_o;
  endtask

  task automatic check_sb(input string name);
    exp_w = exp_q.pop_front();
    n_cmp++;
    if ({obs_take, obs_vec, obs_b} !== exp_w) begin
      n_err++;
      $display("FAIL %s: got take=%b vec=%h B=%b, want take=%b vec=%h B=%b",
               name, obs_take, obs_vec, obs_b, exp_w[9], exp_w[8:1], exp_w[0]);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    n_cmp++;
    if (obs_vec !== VEC_RST || obs_b !== 1'b0 || obs_rdy !== 1'b1 || obs_state !== RUN) begin
      n_err++;
      $display("FAIL reset_state: got vec=%h B=%b rdy=%b st=%0d, want FC 0 1 0",
               obs_vec, obs_b, obs_rdy, obs_state);
    end
    reset = 1'b0;
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    exp_q.push_back({1'b1, VEC_RST, 1'b0});
    cycle(1, 0, 0, 0, 0);
    check_sb("reset_take");
    cycle(0, 0, 1, 0, 0);
    exp_q.push_back({1'b0, VEC_RST, 1'b0});
    cycle(1, 0, 0, 0, 0);
    check_sb("reset_cleared");
  endtask

  task automatic test_nmi();
    nmi_n = 1'b0;
    cycle(0, 0, 0, 0, 0);
    exp_q.push_back({1'b1, VEC_NMI, 1'b0});
    cycle(1, 0, 0, 0, 0);
    check_sb("nmi_take");
    cycle(0, 0, 1, 0, 0);
    exp_q.push_back({1'b0, VEC_NMI, 1'b0});
    cycle(1, 0, 0, 0, 0);
    check_sb("nmi_no_retrigger");
    nmi_n = 1'b1;
    cycle(0, 0, 0, 0, 0);
  endtask

  task automatic test_nmi_set_wins();
    nmi_n = 1'b0;
    cycle(0, 0, 0, 0, 0);
    nmi_n = 1'b1;
    exp_q.push_back({1'b1, VEC_NMI, 1'b0});
    cycle(1, 0, 0, 0, 0);
    check_sb("nmi_second_take");
    nmi_n = 1'b0;                 // new edge in the same cycle as the clear
    cycle(0, 0, 1, 0, 0);
    exp_q.push_back({1'b1, VEC_NMI, 1'b0});
    cycle(1, 0, 0, 0, 0);
    check_sb("nmi_set_wins");
    cycle(0, 0, 1, 0, 0);
    nmi_n = 1'b1;
    cycle(0, 0, 0, 0, 0);
  endtask

  task automatic test_irq_brk();
    irq_n = 1'b0; I = 1'b1;
    exp_q.push_back({1'b0, VEC_IRQ, 1'b1});
    cycle(1, 1, 0, 0, 0);
    check_sb("brk_masked_irq");
    I = 1'b0;
    exp_q.push_back({1'b1, VEC_IRQ, 1'b0});
    cycle(1, 0, 0, 0, 0);
    check_sb("irq_take");
    irq_n = 1'b1; I = 1'b1;
  endtask

  task automatic test_priority();
    I = 1'b0; irq_n = 1'b0; nmi_n = 1'b0;
    cycle(0, 0, 0, 0, 0);
    exp_q.push_back({1'b1, VEC_NMI, 1'b0});
    cycle(1, 0, 0, 0, 0);
    check_sb("prio_nmi_over_irq");
    cycle(0, 0, 1, 0, 0);
    exp_q.push_back({1'b1, VEC_IRQ, 1'b0});
    cycle(1, 0, 0, 0, 0);
    check_sb("prio_irq_after_nmi");
    nmi_n = 1'b1; irq_n = 1'b1; I = 1'b1;
    cycle(0, 0, 0, 0, 0);
  endtask

  task automatic test_wai();
    // masked IRQ wakes but is not taken
    cycle(0, 0, 0, 1, 0);
    n_cmp++;
    if (obs_rdy !== 1'b0 || obs_state !== WAIT) begin
      n_err++;
      $display("FAIL wai_halt: got rdy=%b st=%0d, want 0 1", obs_rdy, obs_state);
    end
    cycle(0, 0, 0, 0, 0);
    n_cmp++;
    if (obs_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL wai_hold: got rdy=%b, want 0", obs_rdy);
    end
    irq_n = 1'b0;
    cycle(0, 0, 0, 0, 0);
    n_cmp++;
    if (obs_rdy !== 1'b1 || obs_state !== RUN) begin
      n_err++;
      $display("FAIL wai_wake_masked: got rdy=%b st=%0d, want 1 0", obs_rdy, obs_state);
    end
    exp_q.push_back({1'b0, VEC_IRQ, 1'b0});
    cycle(1, 0, 0, 0, 0);
    check_sb("wai_masked_no_take");
    // unmasked: sync during WAIT ignored, then taken at next sync
    irq_n = 1'b1; I = 1'b0;
    cycle(0, 0, 0, 1, 0);
    irq_n = 1'b0;
    exp_q.push_back({1'b0, VEC_IRQ, 1'b0});
    cycle(1, 0, 0, 0, 0);
    check_sb("wai_sync_ignored");
    n_cmp++;
    if (obs_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL wai_wake: got rdy=%b, want 1", obs_rdy);
    end
    exp_q.push_back({1'b1, VEC_IRQ, 1'b0});
    cycle(1, 0, 0, 0, 0);
    check_sb("wai_irq_take");
    irq_n = 1'b1; I = 1'b1;
  endtask

  task automatic test_stp();
    cycle(0, 0, 0, 1, 1);   // stp wins over wai
    n_cmp++;
    if (obs_rdy !== 1'b0 || obs_state !== STOP) begin
      n_err++;
      $display("FAIL stp_halt: got rdy=%b st=%0d, want 0 2", obs_rdy, obs_state);
    end
    nmi_n = 1'b0; irq_n = 1'b0; I = 1'b0;
    exp_q.push_back({1'b0, VEC_IRQ, 1'b0});
    cycle(1, 0, 0, 0, 0);
    check_sb("stp_sync_ignored");
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    n_cmp++;
    if (obs_rdy !== 1'b0 || obs_state !== STOP) begin
      n_err++;
      $display("FAIL stp_stays: got rdy=%b st=%0d, want 0 2", obs_rdy, obs_state);
    end
    reset = 1'b1;
    cycle(0, 0, 0, 0, 0);
    reset = 1'b0; nmi_n = 1'b1; irq_n = 1'b1; I = 1'b1;
    n_cmp++;
    if (obs_rdy !== 1'b1 || obs_state !== RUN || obs_vec !== VEC_RST || obs_b !== 1'b0) begin
      n_err++;
      $display("FAIL stp_reset_exit: got rdy=%b st=%0d vec=%h B=%b, want 1 0 FC 0",
               obs_rdy, obs_state, obs_vec, obs_b);
    end
  endtask

  task automatic test_random_sync();
    logic [7:0] m_vec;
    logic       m_b, r_irq, r_i, r_brk, m_eff;
    exp_q.push_back({1'b1, VEC_RST, 1'b0});
    cycle(1, 0, 0, 0, 0);
    check_sb("rand_reset_take");
    cycle(0, 0, 1, 0, 0);
    m_vec = VEC_RST; m_b = 1'b0;
    for (int k = 0; k < 16; k++) begin
      r_irq = 1'($urandom_range(0, 1));
      r_i   = 1'($urandom_range(0, 1));
      r_brk = 1'($urandom_range(0, 1));
      irq_n = r_irq; I = r_i;
      m_eff = ~r_irq & ~r_i;
      if (m_eff)      begin m_vec = VEC_IRQ; m_b = 1'b0; end
      else if (r_brk) begin m_vec = VEC_IRQ; m_b = 1'b1; end
      exp_q.push_back({m_eff, m_vec, m_b});
      cycle(1, r_brk, 0, 0, 0);
      check_sb("rand_sync");
    end
    irq_n = 1'b1; I = 1'b1;
    cycle(0, 0, 0, 0, 0);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b1; irq_n = 1'b1; nmi_n = 1'b1; I = 1'b1;
    sync = 1'b0; brk = 1'b0; wai = 1'b0; stp = 1'b0; vec_fetch = 1'b0;
    test_reset();
    test_nmi();
    test_nmi_set_wins();
    test_irq_brk();
    test_priority();
    test_wai();
    test_stp();
    test_random_sync();
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d entries, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
